nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder built from one CLA4 slice, processing one 4-bit nibble per clock, LSB first.
- Ripples the carry through a register between nibbles.
- Sits directly upstream of the CLA4 slice: sequences operand nibbles and carry-in into it, then collects its S, Co, PG and GG outputs into a full-width result.
- Used where a wide add is needed but area allows only one CLA4.

---
 rtl/nibble_serial_adder.sv | 164 ++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one CLA4 slice, one nibble per clock, LSB first.
// Define NIBBLE_SERIAL_ADDER_GROUP_PG_EN to add group propagate/generate outputs pg and gg.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       pg,
  output logic       gg
);
  logic [3:0] p, g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Two-level lookahead; every carry is a flat sum of products of p/g and ci.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign co = gg | (pg & ci);

  for (genvar i = 0; i < 4; i++) begin : g_sum
    assign s[i] = p[i] ^ c[i];
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
`ifdef NIBBLE_SERIAL_ADDER_GROUP_PG_EN
  output logic             ovf,
  output logic             pg,
  output logic             gg
`else
  output logic             ovf
`endif
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [NIB-1:0][3:0]   a_lat, b_lat, sum_q;
  logic [CW-1:0]         cnt;
  logic                  carry;
  logic                  last;

  logic [3:0]            nib_a, nib_b, nib_s;
  logic                  nib_co, nib_pg, nib_gg;

  assign nib_a = a_lat[cnt];
  assign nib_b = b_lat[cnt];
  assign last  = (cnt == CW'(NIB - 1));
  assign sum   = sum_q;

  cla4 u_cla4 (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co),
    .pg (nib_pg),
    .gg (nib_gg)
  );

`ifdef NIBBLE_SERIAL_ADDER_GROUP_PG_EN
  // Running group terms; folded into pg/gg on the final nibble only.
  logic pg_acc, gg_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pg_acc <= 1'b0;
      gg_acc <= 1'b0;
      pg     <= 1'b0;
      gg     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pg_acc <= 1'b1;
          gg_acc <= 1'b0;
        end
        RUN: begin
          pg_acc <= pg_acc & nib_pg;
          gg_acc <= nib_gg | (nib_pg & gg_acc);
          if (last) begin
            pg <= pg_acc & nib_pg;
            gg <= nib_gg | (nib_pg & gg_acc);
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_grp;
  assign unused_grp = nib_pg ^ nib_gg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum_q <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_lat <= a;
            b_lat <= b;
            carry <= ci;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Result is overwritten in place; earlier nibbles of the last result stay visible.
          sum_q[cnt] <= nib_s;
          carry      <= nib_co;
          cnt        <= cnt + 1'b1;
          if (last) begin
            co    <= nib_co;
            ovf   <= (a_lat[NIB-1][3] == b_lat[NIB-1][3]) && (nib_s[3] != a_lat[NIB-1][3]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): latency, result, overflow, ignored starts, reset abort.
module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n, start, ci;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, co, ovf;
  logic [WIDTH-1:0] sum;
`ifdef NIBBLE_SERIAL_ADDER_GROUP_PG_EN
  logic             pg, gg;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co),
`ifdef NIBBLE_SERIAL_ADDER_GROUP_PG_EN
    .ovf   (ovf),
    .pg    (pg),
    .gg    (gg)
`else
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: start for one edge, scramble operands, check busy window and result.
  task automatic run(input string tag, input logic [15:0] ra, input logic [15:0] rb, input logic rci,
                     input logic [15:0] es, input logic eco, input logic eovf,
                     input logic epg, input logic egg);
    a = ra; b = rb; ci = rci; start = 1'b1;
    tick();
    start = 1'b0; a = 16'hA5A5; b = 16'h5A5A; ci = ~rci;
    for (int i = 0; i < NIB; i++) begin
      chk({tag, "_busy"}, {30'd0, busy, done}, 32'h2);
      tick();
    end
    chk({tag, "_done"}, {30'd0, busy, done}, 32'h1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_co"}, co, eco);
    chk({tag, "_ovf"}, ovf, eovf);
`ifdef NIBBLE_SERIAL_ADDER_GROUP_PG_EN
    chk({tag, "_pg"}, pg, epg);
    chk({tag, "_gg"}, gg, egg);
`else
    if (epg === 1'bx || egg === 1'bx) $display("note: %s group terms undefined", tag);
`endif
    tick();
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'h0);
  endtask

  initial begin
    int ndone, t1, t2;
    bit seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    tick(); tick();
    chk("rst_state", {sum, 13'd0, busy, done, co} | {31'd0, ovf}, 32'h0);
`ifdef NIBBLE_SERIAL_ADDER_GROUP_PG_EN
    chk("rst_grp", {pg, gg}, 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    run("basic",  16'h0001, 16'h000A, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0);
    run("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run("povf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    run("novf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

    // Starts during busy and during the done cycle must be ignored.
    a = 16'h0003; b = 16'h0009; ci = 1'b1; start = 1'b1;
    tick();
    a = 16'hFFFF; b = 16'hFFFF; ci = 1'b0;
    ndone = 0;
    for (int i = 0; i < NIB + 1; i++) begin
      if (done) ndone++;
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 2 * NIB; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("ign_ndone", ndone, 32'd1);
    chk("ign_sum", sum, 32'h000D);
    chk("ign_busy", busy, 32'h0);

    // Reset during RUN aborts immediately.
    a = 16'h1234; b = 16'h1111; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_partial", sum, 32'h0005);
    rst_n = 1'b0;
    tick();
    chk("abort_state", {sum, 13'd0, busy, done, co}, 32'h0);
    rst_n = 1'b1;
    tick();
    run("post_rst", 16'h0007, 16'h0002, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: second start held from the done cycle.
    a = 16'h00F0; b = 16'h0010; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NIB; i++) tick();
    chk("b2b_done1", done, 32'h1);
    chk("b2b_sum1", sum, 32'h0100);
    t1 = cyc;
    a = 16'h2222; b = 16'h1111; start = 1'b1;
    tick();
    chk("b2b_hold_idle", sum, 32'h0100);
    tick();
    start = 1'b0;
    chk("b2b_hold_run", sum, 32'h0100);
    tick();
    chk("b2b_overwrite", sum, 32'h0103);
    seen = 1'b0;
    t2 = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) begin seen = 1'b1; t2 = cyc; end
      else tick();
    end
    chk("b2b_seen", seen, 32'h1);
    chk("b2b_gap", t2 - t1, NIB + 2);
    chk("b2b_sum2", sum, 32'h3333);
    chk("b2b_co2", co, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
